// File: rtl/vo_seq_pkg.sv
// Shared types and widths for the visual-odometry frame sequencer.
package vo_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        STREAM,
        DRAIN,
        GAP
    } seq_state_e;

    localparam int PIX_W   = 8;
    localparam int DEPTH_W = 16;
    localparam int FCNT_W  = 16;

    // Counter width that stays at least one bit for degenerate sizes of 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vo_raster_cnt.sv
// Raster position tracker: x/y advance once per accepted beat and wrap at frame end.
module vo_raster_cnt
    import vo_seq_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic clk,
    input  logic rst,
    input  logic advance,
    output logic last_pix
);

    localparam int XW = cnt_w(WIDTH);
    localparam int YW = cnt_w(HEIGHT);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          x_last;
    logic          y_last;

    assign x_last   = (x == XW'(WIDTH - 1));
    assign y_last   = (y == YW'(HEIGHT - 1));
    assign last_pix = x_last && y_last;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vo_frame_sequencer.sv
// Frames a pixel+depth stream into WIDTH*HEIGHT beats for the CHIP pipeline and sequences frames.
// Optional statistics outputs are enabled by defining VO_FRAME_SEQ_STATS_EN.
module vo_frame_sequencer
    import vo_seq_pkg::*;
#(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int TIMEOUT_CYC = 1048576,
    parameter int FRAME_GAP   = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_go,
    input  logic               i_err_clr,
    input  logic               i_src_valid,
    output logic               o_src_ready,
    input  logic [PIX_W-1:0]   i_src_pixel,
    input  logic [DEPTH_W-1:0] i_src_depth,
    output logic               o_frame_start,
    output logic               o_valid,
    output logic [PIX_W-1:0]   o_pixel,
    output logic [DEPTH_W-1:0] o_depth,
    input  logic               i_chip_ready,
    input  logic               i_chip_frame_end,
    output logic               o_busy,
    output logic [FCNT_W-1:0]  o_frame_cnt,
    output logic               o_err_timeout,
    output logic               o_err_seq
`ifdef VO_FRAME_SEQ_STATS_EN
    ,
    output logic [31:0]        o_stall_cnt,
    output logic [23:0]        o_last_drain_cyc
`endif
);

    localparam int TW = cnt_w(TIMEOUT_CYC);
    localparam int GW = cnt_w(FRAME_GAP);

    seq_state_e    state;
    seq_state_e    state_n;
    logic [TW-1:0] tcnt;
    logic [GW-1:0] gcnt;
    logic          go_pend;
    logic          accept;
    logic          last_pix;
    logic          frame_done;
    logic          timed_out;
    logic          seq_err;

    // Ready is the only combinational input-to-output path; it never leaks outside STREAM.
    assign o_src_ready   = (state == STREAM) && i_chip_ready;
    assign accept        = i_src_valid && o_src_ready;
    assign o_frame_start = (state == START);
    assign o_busy        = (state != IDLE);
    assign seq_err       = i_chip_frame_end && (state != DRAIN);

    vo_raster_cnt #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_raster (
        .clk      (i_clk),
        .rst      (i_rst),
        .advance  (accept),
        .last_pix (last_pix)
    );

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n    = state;
        frame_done = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE:    if (i_go || go_pend) state_n = START;
            START:   state_n = STREAM;
            STREAM:  if (accept && last_pix) state_n = DRAIN;
            DRAIN: begin
                // A frame end on the final timeout cycle still counts as a clean end.
                if (i_chip_frame_end) begin
                    frame_done = 1'b1;
                    state_n    = GAP;
                end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                    timed_out = 1'b1;
                    state_n   = GAP;
                end
            end
            GAP:     if (gcnt == GW'(FRAME_GAP - 1)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            tcnt    <= '0;
            gcnt    <= '0;
            go_pend <= 1'b0;
        end else begin
            state <= state_n;
            tcnt  <= (state == DRAIN) ? tcnt + 1'b1 : '0;
            gcnt  <= (state == GAP) ? gcnt + 1'b1 : '0;
            // One-deep request memory; requests arriving while one is pending are dropped.
            if (state == IDLE) go_pend <= 1'b0;
            else if (i_go)     go_pend <= 1'b1;
        end
    end

    // Beat registers are reset too, since all outputs must read zero after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_pixel <= '0;
            o_depth <= '0;
        end else begin
            o_valid <= accept;
            if (accept) begin
                o_pixel <= i_src_pixel;
                o_depth <= i_src_depth;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_frame_cnt   <= '0;
            o_err_timeout <= 1'b0;
            o_err_seq     <= 1'b0;
        end else begin
            if (frame_done) o_frame_cnt <= o_frame_cnt + 1'b1;
            // A new error in the same cycle as a clear wins.
            if (timed_out)      o_err_timeout <= 1'b1;
            else if (i_err_clr) o_err_timeout <= 1'b0;
            if (seq_err)        o_err_seq <= 1'b1;
            else if (i_err_clr) o_err_seq <= 1'b0;
        end
    end

`ifdef VO_FRAME_SEQ_STATS_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_stall_cnt      <= '0;
            o_last_drain_cyc <= '0;
        end else begin
            if (i_err_clr)
                o_stall_cnt <= '0;
            else if (state == STREAM && i_src_valid && !i_chip_ready && o_stall_cnt != '1)
                o_stall_cnt <= o_stall_cnt + 1'b1;
            if (state == DRAIN && state_n != DRAIN)
                o_last_drain_cyc <= 24'(tcnt);
        end
    end
`endif

endmodule

// File: doc/vo_frame_sequencer.md
Name: vo_frame_sequencer

Overview:
Frame-level controller placed in front of the CHIP feature/match pipeline (FAST -> BRIEF -> MATCH).
- Accepts a raw pixel+depth stream from the sensor-side source under a valid/ready handshake.
- Frames it into exactly WIDTH*HEIGHT beats, issues the frame-start pulse, and applies backpressure from the pipeline's ready.
- Holds off the next frame until the pipeline reports frame end, with timeout and sequencing-error reporting.

Parameters:
WIDTH, 640, pixels per line
HEIGHT, 480, lines per frame
TIMEOUT_CYC, 1048576, max cycles in DRAIN waiting for pipeline frame end
FRAME_GAP, 4, idle cycles inserted after each frame, minimum 1

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous reset, active-high
i_go  in  1  request one frame (pulse)
i_err_clr  in  1  clears sticky error flags
i_src_valid  in  1  source beat valid
o_src_ready  out  1  source beat accepted when high with i_src_valid
i_src_pixel  in  8  source grey pixel
i_src_depth  in  16  source depth
o_frame_start  out  1  one-cycle frame-start pulse to pipeline
o_valid  out  1  pixel valid to pipeline
o_pixel  out  8  pixel to pipeline
o_depth  out  16  depth to pipeline
i_chip_ready  in  1  pipeline ready (may drop at any cycle)
i_chip_frame_end  in  1  pipeline frame-end pulse
o_busy  out  1  state != IDLE
o_frame_cnt  out  16  completed frames, wraps 0xFFFF->0
o_err_timeout  out  1  sticky, DRAIN timed out
o_err_seq  out  1  sticky, frame end outside DRAIN

Behaviour:
- Reset: state IDLE; all outputs 0; x, y, timeout counter, gap counter, go_pend, frame_cnt all 0.
- Reset mid-frame aborts immediately. No partial-frame flush.
- States: IDLE, START, STREAM, DRAIN, GAP.
- IDLE -> START when i_go or go_pend is set; go_pend clears on this transition.
- START: o_frame_start=1 for exactly one cycle, o_valid=0, then -> STREAM.
- STREAM:
  - o_src_ready = i_chip_ready. This is the only combinational path; it is forced 0 outside STREAM.
  - A beat is accepted on i_src_valid && o_src_ready.
  - An accepted beat is registered: o_valid/o_pixel/o_depth appear the next cycle for one cycle. o_valid=0 otherwise; o_pixel/o_depth hold their last value.
  - x increments per accepted beat. At x=WIDTH-1, x->0 and y++.
  - Accepting beat (WIDTH-1, HEIGHT-1) -> DRAIN in the same edge, so o_src_ready is 0 from the next cycle.
- DRAIN: o_src_ready=0. The timeout counter starts at 0 on entry and increments each cycle.
  - i_chip_frame_end -> frame_cnt++, -> GAP.
  - Counter reaching TIMEOUT_CYC-1 with no end -> o_err_timeout=1, -> GAP. frame_cnt is not incremented.
  - Frame end on the exact timeout cycle counts as a normal end, with no error.
- GAP: FRAME_GAP cycles, then -> IDLE.
- i_go in any state other than IDLE sets go_pend. It is one deep; extra requests are dropped silently.
- i_chip_frame_end in IDLE/START/STREAM/GAP: ignored for counting, sets o_err_seq.
- i_err_clr clears both flags. A simultaneous error set wins over the clear.
- x/y counter widths: $clog2(WIDTH) and $clog2(HEIGHT).
- No pixel is ever dropped or duplicated: source beats accepted = pipeline o_valid pulses = WIDTH*HEIGHT per frame.

Optional Feature:
VO_FRAME_SEQ_STATS_EN:
- When defined, adds output o_stall_cnt[31:0] and output o_last_drain_cyc[23:0].
  - o_stall_cnt counts STREAM cycles with i_src_valid=1 and i_chip_ready=0. It saturates at max, clears on reset or i_err_clr.
  - o_last_drain_cyc latches the DRAIN timeout-counter value on exit from DRAIN.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package vo_seq_pkg: state enum seq_state_e {IDLE, START, STREAM, DRAIN, GAP}; localparams for pixel width 8, depth width 16, frame-count width 16.
- One sub-module, vo_raster_cnt, holds the x/y counters with an advance input and a last_pix output (x==WIDTH-1 && y==HEIGHT-1).

Test Plan (WIDTH=4, HEIGHT=2, FRAME_GAP=2, TIMEOUT_CYC=16 unless noted):
- Basic frame, source always valid, ready high: i_go -> o_frame_start pulse 1 cycle, then 8 consecutive o_valid pulses in order. Frame end 3 cycles later -> o_frame_cnt=1, o_busy drops after 2 gap cycles.
- Backpressure: i_chip_ready toggles 1,0,0,1,... -> o_src_ready tracks it each cycle, exactly 8 o_valid, pixel order preserved, with stats enabled o_stall_cnt equals the ready=0 cycles where source was valid.
- Timeout: no frame end after last beat -> 16 DRAIN cycles, o_err_timeout=1, frame_cnt unchanged; i_err_clr -> flag 0.
- Sequencing error: frame end pulsed during STREAM -> o_err_seq=1, streaming continues unaffected, frame still needs a DRAIN end.
- Pending go: i_go twice during STREAM -> exactly one follow-on frame starts after GAP without a new i_go; frame_cnt ends at 2.
- Async reset asserted mid-STREAM (after 3 beats) -> all outputs 0 immediately, next i_go restarts at x=0,y=0 and delivers 8 beats.
